conv_window_gen: RTL

- Streaming producer of K_H x K_W convolution windows. It feeds the combinational conv unit's window input.
- Accepts a raster-order pixel stream, one pixel per handshake. Buffers K_H-1 previous rows in line buffers.
- Emits every "valid" window position (no padding, stride 1) with a valid/ready handshake.
- Sits between the feature-map reader and the conv unit. Each window's conv result is one output pixel.

---
 rtl/conv_pkg.sv | 18 +
 rtl/conv_line_buffer.sv | 31 +++
 rtl/conv_window_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | conv_pkg: shared window geometry for the window gen & conv unit |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
package conv_pkg;

   localparam int DATA_W_DEF = 9;
   localparam int K_H_DEF    = 3;
   localparam int K_W_DEF    = 3;

   // Flat element index of window position (r,c); r=0 is the oldest row.
   function automatic int win_idx(input int r, input int c, input int k_w);
      return r * k_w + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | conv_line_buffer: one image row of storage, read-before-write   |
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   assign rd_data = mem_q[addr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[addr] <= wr_data;
      end
   end

endmodule
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | conv_window_gen: raster pixel stream -> K_H x K_W sliding window|
// | rev 1.0                                                         |
// +-----------------------------------------------------------------+
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int K_H    = K_H_DEF,
   parameter int K_W    = K_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_pixel,
   output logic                      win_valid,
   input  logic                      win_ready,
   output logic [K_H*K_W*DATA_W-1:0] win_data,
   output logic                      win_last
);

   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

   logic              acc;
   logic              window_pos;
   logic              frame_end;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              win_valid_q, win_valid_d;
   logic              win_last_q, win_last_d;
   logic [DATA_W-1:0] win_q [K_H][K_W];
   logic [DATA_W-1:0] win_d [K_H][K_W];
   logic [DATA_W-1:0] lb_rd [K_H-1];
   logic [DATA_W-1:0] lb_wr [K_H-1];

   assign in_ready   = !win_valid_q || win_ready;
   assign acc        = in_valid && in_ready;
   assign window_pos = (row_q >= ROW_W'(K_H - 1)) && (col_q >= COL_W'(K_W - 1));
   assign frame_end  = (row_q == LAST_ROW) && (col_q == LAST_COL);
   assign win_valid  = win_valid_q;
   assign win_last   = win_last_q;

   // Each buffer takes the value the buffer below it held at this column,
   // so the stack always holds the K_H-1 rows preceding the current one.
   generate
      for (genvar k = 0; k < K_H - 1; k++) begin : g_lbuf
         conv_line_buffer #(
            .DEPTH  (IMG_W),
            .DATA_W (DATA_W)
         ) u_lbuf (
            .clk     (clk),
            .wr_en   (acc),
            .addr    (col_q),
            .wr_data (lb_wr[k]),
            .rd_data (lb_rd[k])
         );
         if (k == K_H - 2) begin : g_bottom
            assign lb_wr[k] = in_pixel;
         end else begin : g_upper
            assign lb_wr[k] = lb_rd[k+1];
         end
      end

      for (genvar r = 0; r < K_H; r++) begin : g_pack_r
         for (genvar c = 0; c < K_W; c++) begin : g_pack_c
            localparam int IDX = win_idx(r, c, K_W);
            assign win_data[IDX*DATA_W +: DATA_W] = win_q[r][c];
         end
      end
   endgenerate

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      win_valid_d = win_valid_q;
      win_last_d  = win_last_q;
      win_d       = win_q;
      if (acc) begin
         if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
         for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W - 1; c++) begin
               win_d[r][c] = win_q[r][c+1];
            end
         end
         for (int r = 0; r < K_H - 1; r++) begin
            win_d[r][K_W-1] = lb_rd[r];
         end
         win_d[K_H-1][K_W-1] = in_pixel;
         win_valid_d = window_pos;
         win_last_d  = window_pos && frame_end;
      end else if (win_ready) begin
         win_valid_d = 1'b0;
         win_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q       <= '0;
         row_q       <= '0;
         win_valid_q <= 1'b0;
         win_last_q  <= 1'b0;
         for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_valid_q <= win_valid_d;
         win_last_q  <= win_last_d;
         win_q       <= win_d;
      end
   end

endmodule
`default_nettype wire
